clause_bin_unloader: RTL and testbench

Reads every clause row back out of a solved bin's clause array, one row per request, and streams the non-empty rows to global clause memory over a valid/ready write port. It is the read-side counterpart of the bin loader that fills the array through the one-hot `wr_i` strobes. It also checks each row's literal count against its stored length and flags corrupt rows. It sits between the clause array and the global clause store, and runs after the bin solver finishes, including the learnt clauses inserted during solving.

---
 rtl/sat_bin_pkg.sv | 22 ++
 rtl/clause_lit_check.sv | 25 ++
 rtl/clause_bin_unloader.sv | 132 +++++++++++++
 tb/tb_clause_bin_unloader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_bin_pkg.sv
// Shared definitions for the SAT bin clause-array loader/unloader blocks:
// literal encodings, default geometry and the unloader state type.
package sat_bin_pkg;

  localparam logic [1:0] LIT_NONE    = 2'b00;
  localparam logic [1:0] LIT_POS     = 2'b01;
  localparam logic [1:0] LIT_NEG     = 2'b10;
  localparam logic [1:0] LIT_ILLEGAL = 2'b11;

  localparam int unsigned NUM_CLAUSES_A_BIN_DEF = 8;
  localparam int unsigned WIDTH_ROW_IDX         = $clog2(NUM_CLAUSES_A_BIN_DEF);
  localparam int unsigned WIDTH_NUM_WRITTEN     = WIDTH_ROW_IDX + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_SEND,
    ST_DONE
  } unloader_state_e;

endpackage

// File: rtl/clause_lit_check.sv
// Combinational row inspection: counts present literals and flags any
// field carrying the illegal 11 encoding.
module clause_lit_check
  import sat_bin_pkg::*;
#(
  parameter int unsigned NUM_VARS_A_BIN = 8,
  parameter int unsigned WIDTH_C_LEN    = 5
) (
  input  logic [NUM_VARS_A_BIN*2-1:0] clause_i,
  output logic [WIDTH_C_LEN-1:0]      lit_cnt_o,
  output logic                        illegal_o
);

  always_comb begin
    lit_cnt_o = '0;
    illegal_o = 1'b0;
    for (int unsigned i = 0; i < NUM_VARS_A_BIN; i++) begin
      if (clause_i[2*i +: 2] != LIT_NONE)
        lit_cnt_o = lit_cnt_o + WIDTH_C_LEN'(1);
      if (clause_i[2*i +: 2] == LIT_ILLEGAL)
        illegal_o = 1'b1;
    end
  end

endmodule

// File: rtl/clause_bin_unloader.sv
// Walks every row of a solved bin's clause array and streams non-empty,
// well-formed rows to global clause memory over a valid/ready port.
module clause_bin_unloader
  import sat_bin_pkg::*;
#(
  parameter int unsigned NUM_CLAUSES_A_BIN = 8,
  parameter int unsigned NUM_VARS_A_BIN    = 8,
  parameter int unsigned WIDTH_C_LEN       = 5,
  parameter int unsigned WIDTH_BIN_ID      = 10
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              start_i,
  input  logic [WIDTH_BIN_ID-1:0]                           bin_id_i,
  output logic [NUM_CLAUSES_A_BIN-1:0]                      rd_o,
  input  logic [NUM_VARS_A_BIN*2-1:0]                       clause_i,
  input  logic [WIDTH_C_LEN-1:0]                            clause_len_i,
  output logic                                              mem_wr_valid_o,
  input  logic                                              mem_wr_ready_i,
  output logic [WIDTH_BIN_ID+$clog2(NUM_CLAUSES_A_BIN)-1:0] mem_wr_addr_o,
  output logic [NUM_VARS_A_BIN*2-1:0]                       mem_wr_data_o,
  output logic [WIDTH_C_LEN-1:0]                            mem_wr_len_o,
  output logic                                              busy_o,
  output logic                                              done_o,
  output logic [$clog2(NUM_CLAUSES_A_BIN):0]                num_written_o,
  output logic                                              error_o
);

  localparam int unsigned IDX_W = $clog2(NUM_CLAUSES_A_BIN);
  localparam int unsigned CNT_W = IDX_W + 1;

  unloader_state_e state_q, state_d;

  logic [WIDTH_BIN_ID-1:0]     bin_id_q;
  logic [IDX_W-1:0]            idx_q;
  logic [NUM_VARS_A_BIN*2-1:0] data_q;
  logic [WIDTH_C_LEN-1:0]      len_q;
  logic [CNT_W-1:0]            num_written_q;
  logic                        error_q;

  logic [WIDTH_C_LEN-1:0] lit_cnt;
  logic                   illegal;
  logic                   row_empty;
  logic                   row_corrupt;
  logic                   row_skip;
  logic                   last_row;
  logic                   handshake;

  clause_lit_check #(
    .NUM_VARS_A_BIN (NUM_VARS_A_BIN),
    .WIDTH_C_LEN    (WIDTH_C_LEN)
  ) u_lit_check (
    .clause_i  (clause_i),
    .lit_cnt_o (lit_cnt),
    .illegal_o (illegal)
  );

  // Classification uses the live array output during CAPTURE so a skipped
  // row costs only READ+CAPTURE.
  assign row_empty   = (clause_i == '0) && (clause_len_i == '0);
  assign row_corrupt = !row_empty && (illegal || (lit_cnt != clause_len_i));
  assign row_skip    = row_empty || row_corrupt;
  assign last_row    = (idx_q == IDX_W'(NUM_CLAUSES_A_BIN - 1));
  assign handshake   = (state_q == ST_SEND) && mem_wr_ready_i;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start_i) state_d = ST_READ;
      ST_READ:    state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        if (!row_skip)     state_d = ST_SEND;
        else if (last_row) state_d = ST_DONE;
        else               state_d = ST_READ;
      end
      ST_SEND:    if (mem_wr_ready_i) state_d = last_row ? ST_DONE : ST_READ;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_id_q      <= '0;
      idx_q         <= '0;
      data_q        <= '0;
      len_q         <= '0;
      num_written_q <= '0;
      error_q       <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            bin_id_q      <= bin_id_i;
            idx_q         <= '0;
            num_written_q <= '0;
            error_q       <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          data_q <= clause_i;
          len_q  <= clause_len_i;
          if (row_corrupt)           error_q <= 1'b1;
          if (row_skip && !last_row) idx_q   <= idx_q + IDX_W'(1);
        end
        ST_SEND: begin
          if (handshake) begin
            num_written_q <= num_written_q + CNT_W'(1);
            if (!last_row) idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_o           = (state_q == ST_READ) ? (NUM_CLAUSES_A_BIN'(1) << idx_q) : '0;
  assign mem_wr_valid_o = (state_q == ST_SEND);
  assign mem_wr_addr_o  = {bin_id_q, idx_q};
  assign mem_wr_data_o  = data_q;
  assign mem_wr_len_o   = len_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = (state_q == ST_DONE);
  assign num_written_o  = num_written_q;
  assign error_o        = error_q;

endmodule

// File: tb/tb_clause_bin_unloader.sv
// Scoreboard bench for clause_bin_unloader: a clause-array responder feeds
// directed rows, a negedge monitor checks every accepted write in order.
module tb_clause_bin_unloader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [9:0]  bin_id_i;
  logic [7:0]  rd_o;
  logic [15:0] clause_i;
  logic [4:0]  clause_len_i;
  logic        mem_wr_valid_o;
  logic        mem_wr_ready_i = 1'b1;
  logic [12:0] mem_wr_addr_o;
  logic [15:0] mem_wr_data_o;
  logic [4:0]  mem_wr_len_o;
  logic        busy_o;
  logic        done_o;
  logic [3:0]  num_written_o;
  logic        error_o;

  always #5 clk = ~clk;

  clause_bin_unloader #(
    .NUM_CLAUSES_A_BIN (8),
    .NUM_VARS_A_BIN    (8),
    .WIDTH_C_LEN       (5),
    .WIDTH_BIN_ID      (10)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .bin_id_i       (bin_id_i),
    .rd_o           (rd_o),
    .clause_i       (clause_i),
    .clause_len_i   (clause_len_i),
    .mem_wr_valid_o (mem_wr_valid_o),
    .mem_wr_ready_i (mem_wr_ready_i),
    .mem_wr_addr_o  (mem_wr_addr_o),
    .mem_wr_data_o  (mem_wr_data_o),
    .mem_wr_len_o   (mem_wr_len_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .num_written_o  (num_written_o),
    .error_o        (error_o)
  );

  // Hand-encoded rows (var0 in bits [1:0]) and their literal counts.
  localparam logic [15:0] ROW_DATA [8] = '{16'h0012, 16'h0848, 16'h0242, 16'h0105,
                                           16'h0224, 16'h0001, 16'h8000, 16'h2411};
  localparam logic [4:0]  ROW_LEN  [8] = '{5'd2, 5'd3, 5'd3, 5'd3, 5'd3, 5'd1, 5'd1, 5'd4};

  typedef struct packed {
    logic [12:0] addr;
    logic [15:0] data;
    logic [4:0]  len;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] rows [8];
  logic [4:0]  lens [8];

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int stall_cnt = 0;
  bit stall_en = 0;
  bit force_low = 0;
  bit stalled = 0;
  wr_t held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Clause array model: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++)
      if (rd_o[i]) begin
        clause_i     <= rows[i];
        clause_len_i <= lens[i];
      end
  end

  // Monitor: drives ready for the coming edge, then judges the write that edge will accept.
  always @(negedge clk) begin
    if (rst) begin
      mem_wr_ready_i = 1'b1;
      stalled = 0;
    end else begin
      if (force_low) begin
        mem_wr_ready_i = 1'b0;
      end else if (stall_en && mem_wr_valid_o && mem_wr_addr_o == 13'd25 && stall_cnt < 3) begin
        mem_wr_ready_i = 1'b0;
        stall_cnt++;
      end else begin
        mem_wr_ready_i = 1'b1;
      end
      if (stalled) begin
        chk("stall_valid", 32'(mem_wr_valid_o), 32'd1);
        chk("stall_addr",  32'(mem_wr_addr_o), 32'(held.addr));
        chk("stall_data",  32'(mem_wr_data_o), 32'(held.data));
        chk("stall_len",   32'(mem_wr_len_o),  32'(held.len));
      end
      if (mem_wr_valid_o && mem_wr_ready_i) begin
        stalled = 0;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: addr 0x%0h with no write expected", mem_wr_addr_o);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 32'(mem_wr_addr_o), 32'(e.addr));
          chk("wr_data", 32'(mem_wr_data_o), 32'(e.data));
          chk("wr_len",  32'(mem_wr_len_o),  32'(e.len));
        end
      end else if (mem_wr_valid_o) begin
        stalled = 1;
        held = '{addr: mem_wr_addr_o, data: mem_wr_data_o, len: mem_wr_len_o};
      end else begin
        stalled = 0;
      end
      if (rd_o != '0) chk("rd_onehot", 32'($onehot(rd_o)), 32'd1);
      if (done_o) done_cnt++;
    end
  end

  task automatic load_rows(input int n);
    for (int i = 0; i < 8; i++) begin
      rows[i] = (i < n) ? ROW_DATA[i] : 16'h0000;
      lens[i] = (i < n) ? ROW_LEN[i]  : 5'd0;
    end
  endtask

  // Bin id 3 places row i at address 24+i.
  task automatic expect_rows(input logic [7:0] mask);
    for (int i = 0; i < 8; i++)
      if (mask[i]) exp_q.push_back('{addr: 13'(24 + i), data: ROW_DATA[i], len: ROW_LEN[i]});
  endtask

  task automatic run_pass(input string tag, input int exp_done_n, input logic [3:0] exp_num,
                          input logic exp_err, input bit extra_start);
    int n;
    bit got;
    done_cnt = 0;
    stall_cnt = 0;
    @(negedge clk);
    bin_id_i = 10'd3;
    start_i  = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk({tag, "_rd_row0"}, 32'(rd_o), 32'h01);
    chk({tag, "_busy"}, 32'(busy_o), 32'd1);
    n = 1;
    got = 0;
    while (n <= 300) begin
      if (n == 3) chk({tag, "_valid_t3"}, 32'(mem_wr_valid_o), 32'd1);
      if (extra_start && n == 4) begin
        start_i  = 1'b1;
        bin_id_i = 10'd5;
      end
      if (n == 6) start_i = 1'b0;
      if (done_o) begin
        got = 1;
        break;
      end
      @(negedge clk);
      n++;
    end
    start_i = 1'b0;
    if (got) chk({tag, "_done_cycle"}, 32'(n), 32'(exp_done_n));
    else begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_done_timeout: no done_o within 300 cycles, expected at cycle %0d", tag, exp_done_n);
    end
    @(negedge clk);
    chk({tag, "_done_pulse_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_done_low"}, 32'(done_o), 32'd0);
    chk({tag, "_idle"}, 32'(busy_o), 32'd0);
    chk({tag, "_num_written"}, 32'(num_written_o), 32'(exp_num));
    chk({tag, "_error"}, 32'(error_o), 32'(exp_err));
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},  32'(busy_o), 32'd0);
    chk({tag, "_done"},  32'(done_o), 32'd0);
    chk({tag, "_rd"},    32'(rd_o), 32'd0);
    chk({tag, "_valid"}, 32'(mem_wr_valid_o), 32'd0);
    chk({tag, "_addr"},  32'(mem_wr_addr_o), 32'd0);
    chk({tag, "_data"},  32'(mem_wr_data_o), 32'd0);
    chk({tag, "_len"},   32'(mem_wr_len_o), 32'd0);
    chk({tag, "_num"},   32'(num_written_o), 32'd0);
    chk({tag, "_err"},   32'(error_o), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    bin_id_i = '0;
    load_rows(5);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // bin1: five rows, three empty
    load_rows(5);
    expect_rows(8'h1F);
    run_pass("bin1", 22, 4'd5, 1'b0, 0);

    // bin2: every row populated
    load_rows(8);
    expect_rows(8'hFF);
    run_pass("bin2", 25, 4'd8, 1'b0, 0);

    // backpressure on row 1
    load_rows(5);
    expect_rows(8'h1F);
    stall_en = 1;
    run_pass("stall", 25, 4'd5, 1'b0, 0);
    chk("stall_cycles", 32'(stall_cnt), 32'd3);
    stall_en = 0;

    // row 2 length disagrees with its literal count
    load_rows(5);
    lens[2] = 5'd5;
    expect_rows(8'h1B);
    run_pass("corrupt_len", 21, 4'd4, 1'b1, 0);

    // row 3 carries an illegal field in var0
    load_rows(5);
    rows[3] = 16'h0107;
    expect_rows(8'h17);
    run_pass("corrupt_ill", 21, 4'd4, 1'b1, 0);

    // start while busy must not restart or retarget the pass
    load_rows(5);
    expect_rows(8'h1F);
    run_pass("busy_start", 22, 4'd5, 1'b0, 1);
    repeat (3) @(negedge clk);
    chk("idle_hold_num", 32'(num_written_o), 32'd5);

    // reset while a write is pending
    force_low = 1;
    expect_rows(8'h1F);
    @(negedge clk);
    bin_id_i = 10'd3;
    start_i  = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    begin
      int w;
      w = 0;
      while (!mem_wr_valid_o && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk("rst_reach_send", 32'(mem_wr_valid_o), 32'd1);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("midrst");
    rst = 1'b0;
    force_low = 0;
    exp_q.delete();

    load_rows(5);
    expect_rows(8'h1F);
    run_pass("after_rst", 22, 4'd5, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
